uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter ADDR_W, default 4; depth = 2^ADDR_W = 16 entries.
REQ-003 glb_clk  input  1  single clock; all state on rising edge.
REQ-004 glb_rstn  input  1  asynchronous, active-low reset.
REQ-005 UART_ctrl_FIFO_w_en  input  1  write strobe from receiver, one cycle per received byte.
REQ-006 UART_Rx_data_payload  input  DATA_W  received byte, valid while w_en high.
REQ-007 FIFO_ctrl_full  output  1  FIFO holds 2^ADDR_W entries; fed back to receiver.
REQ-008 usr_rd_en  input  1  user read strobe.
REQ-009 FIFO_rd_data  output  DATA_W  registered read data.
REQ-010 FIFO_empty  output  1  FIFO holds zero entries.
REQ-011 FIFO_level  output  ADDR_W+1  current entry count, 0..16.
REQ-012 Cfg_ctrl_thresh  input  ADDR_W+1  interrupt threshold; 0 disables.
REQ-013 FIFO_thresh_irq  output  1  level-at-or-above-threshold flag.
REQ-014 FIFO_overrun  output  1  sticky overrun flag.
REQ-015 usr_ovr_clr  input  1  clears FIFO_overrun.
REQ-016 Cfg_ctrl_flush  input  1  synchronous flush of contents.

Function
REQ-017 Storage: 2^ADDR_W x DATA_W register array; write pointer and read pointer ADDR_W bits, wrap 15->0 modulo depth.
REQ-018 Write accepted when w_en=1 and FIFO_ctrl_full=0 at cycle start: data stored at write pointer, pointer +1.
REQ-019 Write with FIFO_ctrl_full=1: data dropped, pointers and level unchanged, FIFO_overrun set next edge; applies even if a read is accepted in the same cycle.
REQ-020 Read accepted when usr_rd_en=1 and FIFO_empty=0 at cycle start: entry at read pointer loaded into FIFO_rd_data on that edge (1-cycle latency), pointer +1.
REQ-021 Read with FIFO_empty=1: ignored, FIFO_rd_data holds previous value, no error flag; applies even if a write is accepted in the same cycle.
REQ-022 Simultaneous accepted read and write: both performed, level unchanged.
REQ-023 FIFO_level: +1 on write only, -1 on read only, held otherwise; never exceeds 16 or goes below 0.
REQ-024 FIFO_empty = (FIFO_level==0); FIFO_ctrl_full = (FIFO_level==16); both derived from registered level, no combinational path from inputs.
REQ-025 FIFO_thresh_irq = (Cfg_ctrl_thresh!=0) and (FIFO_level >= Cfg_ctrl_thresh); thresh > 16 never asserts.
REQ-026 Cfg_ctrl_flush=1: pointers and level to 0 next edge; overrides any same-cycle read or write; FIFO_rd_data and FIFO_overrun unaffected.
REQ-027 FIFO_overrun: set by REQ-019, cleared by usr_ovr_clr; set wins over clear in the same cycle.
REQ-028 Array contents not reset; only pointers, level, flags and FIFO_rd_data are reset.

Reset
REQ-029 glb_rstn=0 asynchronously forces: pointers 0, FIFO_level 0, FIFO_empty 1, FIFO_ctrl_full 0, FIFO_rd_data 0, FIFO_overrun 0, FIFO_thresh_irq 0.
REQ-030 Reset mid-operation discards all stored entries; first write after release lands at address 0.

Verification
REQ-031 Write 0x11,0x22,0x33, then 3 reads -> FIFO_rd_data 0x11,0x22,0x33 each one cycle after its rd_en; FIFO_empty=1 after the third.
REQ-032 16 writes (0x00..0x0F) -> FIFO_ctrl_full=1, level=16; 17th write 0xAA -> dropped, FIFO_overrun=1; 16 reads return 0x00..0x0F.
REQ-033 Level 5, simultaneous write 0x55 and read -> level stays 5, read returns oldest entry; wrap test: 40 write/read pairs return data in order.
REQ-034 Empty FIFO, simultaneous write 0x77 and read -> read ignored, level=1, next read returns 0x77.
REQ-035 Cfg_ctrl_thresh=4: level 3 -> irq 0; 4th write -> irq 1; one read -> irq 0; thresh=0 at level 16 -> irq 0.
REQ-036 Overrun pending, usr_ovr_clr with simultaneous full write -> FIFO_overrun stays 1; flush with level 9 -> level 0, empty 1, overrun unchanged; glb_rstn pulse mid-burst -> all outputs at REQ-029 values.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART receiver and its user: 2^ADDR_W x DATA_W storage,
// registered read data, occupancy level, threshold interrupt and sticky overrun flag.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic              UART_ctrl_FIFO_w_en,
  input  logic [DATA_W-1:0] UART_Rx_data_payload,
  output logic              FIFO_ctrl_full,
  input  logic              usr_rd_en,
  output logic [DATA_W-1:0] FIFO_rd_data,
  output logic              FIFO_empty,
  output logic [ADDR_W:0]   FIFO_level,
  input  logic [ADDR_W:0]   Cfg_ctrl_thresh,
  output logic              FIFO_thresh_irq,
  output logic              FIFO_overrun,
  input  logic              usr_ovr_clr,
  input  logic              Cfg_ctrl_flush
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q,  level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ovr_q, ovr_d;

  logic full, empty;
  logic wr_acc, rd_acc, wr_drop;

  // Full/empty come only from the registered level, so no input reaches them combinationally.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  assign wr_acc  = UART_ctrl_FIFO_w_en & ~full  & ~Cfg_ctrl_flush;
  assign rd_acc  = usr_rd_en           & ~empty & ~Cfg_ctrl_flush;
  assign wr_drop = UART_ctrl_FIFO_w_en &  full;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;

    if (Cfg_ctrl_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // A dropped write sets the flag even when a clear arrives in the same cycle.
  always_comb begin
    ovr_d = ovr_q;
    if (wr_drop)          ovr_d = 1'b1;
    else if (usr_ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      ovr_q     <= ovr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge glb_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= UART_Rx_data_payload;
  end

  assign FIFO_ctrl_full  = full;
  assign FIFO_empty      = empty;
  assign FIFO_level      = level_q;
  assign FIFO_rd_data    = rd_data_q;
  assign FIFO_overrun    = ovr_q;
  assign FIFO_thresh_irq = (Cfg_ctrl_thresh != '0) && (level_q >= Cfg_ctrl_thresh);

endmodule
